// File: rtl/count_dump.sv
// count_dump: readout stage for the two-channel event counter.
// A request snapshots both 64-bit counts, then streams an 18-byte frame
// (header, count0 MSB-first, count1 MSB-first, XOR checksum) over a
// byte-wide valid/ready link.
module count_dump (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [63:0] count0,
   input  logic [63:0] count1,
   input  logic        req,
   input  logic        ready,
   output logic        busy,
   output logic [7:0]  data,
   output logic        valid,
   output logic        done
);

   localparam logic [7:0] HEADER   = 8'hA5;
   localparam logic [4:0] LAST_IDX = 5'd17;

   typedef enum logic {
      IDLE = 1'b0,
      SEND = 1'b1
   } state_t;

   state_t      state_q, state_d;
   logic [4:0]  idx_q,   idx_d;
   logic [63:0] snap0_q, snap0_d;
   logic [63:0] snap1_q, snap1_d;
   logic [7:0]  csum_q,  csum_d;
   logic        done_q,  done_d;

   logic [2:0]  byte_sel;
   logic [7:0]  byte_val;

   // Pick byte 'sel' of a 64-bit word, counting from the most significant byte.
   function automatic logic [7:0] msb_byte(input logic [63:0] word, input logic [2:0] sel);
      logic [63:0] shifted;
      shifted = word << {sel, 3'b000};
      return shifted[63:56];
   endfunction

   // Idx 1..8 and 9..16 both map onto byte positions 0..7 via the low index bits.
   assign byte_sel = idx_q[2:0] - 3'd1;

   // Current frame byte as a function of the index and the held snapshot.
   always_comb begin
      byte_val = 8'h00;
      if (state_q == SEND) begin
         if (idx_q == 5'd0) begin
            byte_val = HEADER;
         end else if (idx_q <= 5'd8) begin
            byte_val = msb_byte(snap0_q, byte_sel);
         end else if (idx_q <= 5'd16) begin
            byte_val = msb_byte(snap1_q, byte_sel);
         end else begin
            byte_val = csum_q;
         end
      end
   end

   // Next-state logic: request accept, per-transfer index/checksum update, frame end.
   always_comb begin
      // NOTE: every signal gets its hold value first, so no branch can leave one
      // unassigned and infer a latch.
      state_d = state_q;
      idx_d   = idx_q;
      snap0_d = snap0_q;
      snap1_d = snap1_q;
      csum_d  = csum_q;
      done_d  = 1'b0;
      case (state_q)
         IDLE: begin
            if (req) begin
               state_d = SEND;
               idx_d   = 5'd0;
               snap0_d = count0;
               snap1_d = count1;
               csum_d  = 8'h00;
            end
         end
         SEND: begin
            if (ready) begin
               if (idx_q >= 5'd1 && idx_q <= 5'd16) begin
                  csum_d = csum_q ^ byte_val;
               end
               if (idx_q == LAST_IDX) begin
                  state_d = IDLE;
                  idx_d   = 5'd0;
                  done_d  = 1'b1;
               end else begin
                  idx_d = idx_q + 5'd1;
               end
            end
         end
         default: begin
            state_d = IDLE;
            idx_d   = 5'd0;
         end
      endcase
   end

   // State and datapath registers with asynchronous active-low reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         idx_q   <= 5'd0;
         // NOTE: the snapshot and checksum registers are reset as well, so the
         // block leaves reset in a completely defined state.
         snap0_q <= 64'd0;
         snap1_q <= 64'd0;
         csum_q  <= 8'h00;
         done_q  <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so every register samples pre-edge values.
         state_q <= state_d;
         idx_q   <= idx_d;
         snap0_q <= snap0_d;
         snap1_q <= snap1_d;
         csum_q  <= csum_d;
         done_q  <= done_d;
      end
   end

   assign busy  = (state_q == SEND);
   assign valid = (state_q == SEND);
   assign data  = byte_val;
   assign done  = done_q;

endmodule

// File: tb/tb_count_dump.sv
// Self-checking bench for count_dump: a vector table for the basic frame,
// plus hand-written sequences for snapshot isolation, backpressure, Req while
// busy, reset mid-frame and back-to-back frames.
module tb_count_dump;

   logic        clk;
   logic        rst_n;
   logic [63:0] count0;
   logic [63:0] count1;
   logic        req;
   logic        ready;
   logic        busy;
   logic [7:0]  data;
   logic        valid;
   logic        done;

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct {
      logic        req;
      logic        ready;
      logic [63:0] c0;
      logic [63:0] c1;
      logic        e_valid;
      logic        e_busy;
      logic [7:0]  e_data;
      logic        e_done;
   } vec_t;

   vec_t       tbl[21];
   logic [7:0] basic_b[18];
   logic [7:0] exp_frame[18];
   logic [7:0] got[18];
   int         got_n;
   int         done_n;

   localparam logic [63:0] BASIC_C0 = 64'h0123456789ABCDEF;
   localparam logic [63:0] BASIC_C1 = 64'h0000000000000003;

   count_dump dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .count0 (count0),
      .count1 (count1),
      .req    (req),
      .ready  (ready),
      .busy   (busy),
      .data   (data),
      .valid  (valid),
      .done   (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Reference frame byte p for counts c0/c1, built from the whole packed frame.
   function automatic logic [7:0] model_byte(input logic [63:0] c0, input logic [63:0] c1, input int p);
      logic [135:0] body;
      logic [7:0]   cs;
      body = {8'hA5, c0, c1};
      if (p < 17) return body[135 - 8*p -: 8];
      cs = 8'h00;
      for (int k = 1; k < 17; k++) cs = cs ^ body[135 - 8*k -: 8];
      return cs;
   endfunction

   function automatic logic [63:0] b2b_c0(input int t);
      return 64'hC0DE000000000000 + 64'(t);
   endfunction

   function automatic logic [63:0] b2b_c1(input int t);
      return 64'h5A5A5A5A00000000 + 64'(t * 3);
   endfunction

   // Issue one request at the current negedge and receive a frame into got[].
   // mode 0: Ready always 1; mode 1: Ready 1,0,0,1 repeating.
   task automatic run_frame(input string tag, input logic [63:0] c0, input logic [63:0] c1,
                            input int mode, input bit inc_c0, input bit req_mid);
      int         cyc;
      bit         rdy;
      bit         prev_stall;
      bit         req_sent;
      logic [7:0] prev_data;
      count0     = c0;
      count1     = c1;
      req        = 1'b1;
      ready      = 1'b1;
      got_n      = 0;
      done_n     = 0;
      cyc        = 0;
      prev_stall = 1'b0;
      req_sent   = 1'b0;
      prev_data  = 8'h00;
      while (done_n == 0 && cyc < 200) begin
         @(negedge clk);
         cyc++;
         req = 1'b0;
         if (inc_c0) count0 = count0 + 64'd1;
         if (prev_stall) begin
            check({tag, " stall valid"}, valid, 1'b1);
            check({tag, " stall data"}, data, prev_data);
         end
         if (done) begin
            done_n++;
            check({tag, " busy at done"}, busy, 1'b0);
            check({tag, " valid at done"}, valid, 1'b0);
         end
         rdy   = (mode == 0) || (cyc % 4 == 1) || (cyc % 4 == 0);
         ready = rdy;
         if (req_mid && got_n == 5 && !req_sent) begin
            req      = 1'b1;
            req_sent = 1'b1;
         end
         if (valid && rdy) begin
            if (got_n < 18) got[got_n] = data;
            got_n++;
         end
         prev_stall = valid && !rdy;
         prev_data  = data;
      end
      check({tag, " done seen"}, done_n, 1);
      check({tag, " byte count"}, got_n, 18);
      for (int i = 0; i < 18; i++) begin
         if (i < got_n) check($sformatf("%s byte %0d", tag, i), got[i], exp_frame[i]);
      end
      @(negedge clk);
      check({tag, " done one cycle"}, done, 1'b0);
      check({tag, " no second frame"}, valid, 1'b0);
   endtask

   initial begin
      logic [143:0] pk;
      int f;
      int p;
      int s;

      rst_n  = 1'b0;
      req    = 1'b0;
      ready  = 1'b0;
      count0 = 64'd0;
      count1 = 64'd0;

      // Basic frame, hand-written bytes.
      pk = 144'hA5_0123456789ABCDEF_0000000000000003_03;
      for (int i = 0; i < 18; i++) basic_b[i] = pk[143 - 8*i -: 8];

      tbl[0] = '{1'b1, 1'b1, BASIC_C0, BASIC_C1, 1'b0, 1'b0, 8'h00, 1'b0};
      for (int i = 1; i <= 18; i++)
         tbl[i] = '{1'b0, 1'b1, BASIC_C0, BASIC_C1, 1'b1, 1'b1, basic_b[i-1], 1'b0};
      tbl[19] = '{1'b0, 1'b1, BASIC_C0, BASIC_C1, 1'b0, 1'b0, 8'h00, 1'b1};
      tbl[20] = '{1'b0, 1'b1, BASIC_C0, BASIC_C1, 1'b0, 1'b0, 8'h00, 1'b0};

      // Reset state.
      repeat (2) @(negedge clk);
      check("reset valid", valid, 1'b0);
      check("reset busy", busy, 1'b0);
      check("reset data", data, 8'h00);
      check("reset done", done, 1'b0);
      rst_n = 1'b1;

      // Table-driven basic frame: check outputs, then apply the row's inputs.
      for (int i = 0; i < 21; i++) begin
         @(negedge clk);
         check($sformatf("tbl[%0d] valid", i), valid, tbl[i].e_valid);
         check($sformatf("tbl[%0d] busy", i), busy, tbl[i].e_busy);
         check($sformatf("tbl[%0d] data", i), data, tbl[i].e_data);
         check($sformatf("tbl[%0d] done", i), done, tbl[i].e_done);
         req    = tbl[i].req;
         ready  = tbl[i].ready;
         count0 = tbl[i].c0;
         count1 = tbl[i].c1;
      end

      for (int i = 0; i < 18; i++) exp_frame[i] = basic_b[i];
      run_frame("snapshot", BASIC_C0, BASIC_C1, 0, 1'b1, 1'b0);
      run_frame("backpressure", BASIC_C0, BASIC_C1, 1, 1'b0, 1'b0);
      run_frame("req_busy", BASIC_C0, BASIC_C1, 0, 1'b0, 1'b1);

      // Reset mid-frame at Idx=10.
      count0 = BASIC_C0;
      count1 = BASIC_C1;
      req    = 1'b1;
      ready  = 1'b1;
      for (int k = 1; k <= 11; k++) begin
         @(negedge clk);
         req = 1'b0;
      end
      check("mid-frame valid before reset", valid, 1'b1);
      check("mid-frame data at idx10", data, basic_b[10]);
      #2 rst_n = 1'b0;
      #1;
      check("async reset valid", valid, 1'b0);
      check("async reset busy", busy, 1'b0);
      check("async reset data", data, 8'h00);
      check("async reset done", done, 1'b0);
      @(negedge clk);
      check("held reset valid", valid, 1'b0);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      check("no frame without req", valid, 1'b0);
      check("no done without req", done, 1'b0);
      pk = 144'hA5_0000000000000000_FFFFFFFFFFFFFFFF_00;
      for (int i = 0; i < 18; i++) exp_frame[i] = pk[143 - 8*i -: 8];
      run_frame("after_reset", 64'd0, 64'hFFFFFFFFFFFFFFFF, 0, 1'b0, 1'b0);

      // Back-to-back: Req held high, counts change every cycle, 19-cycle period.
      for (int t = 0; t <= 58; t++) begin
         if (t > 0) @(negedge clk);
         if (t >= 1 && t <= 57) begin
            f = (t - 1) / 19;
            p = (t - 1) % 19;
            s = 19 * f;
            if (p < 18) begin
               check($sformatf("b2b f%0d valid %0d", f, p), valid, 1'b1);
               check($sformatf("b2b f%0d byte %0d", f, p), data, model_byte(b2b_c0(s), b2b_c1(s), p));
               check($sformatf("b2b f%0d done %0d", f, p), done, 1'b0);
            end else begin
               check($sformatf("b2b f%0d gap done", f), done, 1'b1);
               check($sformatf("b2b f%0d gap valid", f), valid, 1'b0);
               check($sformatf("b2b f%0d gap busy", f), busy, 1'b0);
            end
         end
         if (t == 58) begin
            check("b2b end valid", valid, 1'b0);
            check("b2b end done", done, 1'b0);
         end
         count0 = b2b_c0(t);
         count1 = b2b_c1(t);
         req    = (t < 57);
         ready  = 1'b1;
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/count_dump.md
# count_dump

Downstream readout stage for the two-channel event counter. On a request pulse it snapshots the counter's two 64-bit outputs in one cycle. It then streams them as an 18-byte frame over a byte-wide valid/ready interface to the host-side UART/debug link. The frame carries a header byte, both counts MSB-first, and an XOR checksum.

## Interface
- HEADER, 8'hA5, first byte of every frame.
- Clk  in  1  single clock; all state changes on posedge.
- Reset  in  1  asynchronous, active-low reset.
- Count0  in  64  counter channel 0 value, sampled only at snapshot.
- Count1  in  64  counter channel 1 value, sampled only at snapshot.
- Req  in  1  snapshot/send request; sampled at posedge; level or pulse.
- Busy  out  1  frame in progress.
- Data  out  8  current frame byte.
- Valid  out  1  Data holds a byte to transfer.
- Ready  in  1  sink accepts the byte.
- Done  out  1  one-cycle pulse after the last byte is transferred.

## Operation
- **State machine.** States are IDLE and SEND, plus an internal byte index Idx from 0 to 17.
- **Reset.** Reset low forces IDLE, Idx=0, snapshot registers=0, checksum=0, Busy=0, Valid=0, Data=8'h00, Done=0. This happens immediately, independent of Clk.
- **Request accept.** In IDLE with Req=1 at posedge:
  - Count0 and Count1 are latched into Snap0 and Snap1.
  - State goes to SEND with Idx=0.
- **Req outside IDLE.** Req is ignored in SEND; it is neither queued nor counted.
- **Frame layout**, by Idx:
  - 0: HEADER.
  - 1–8: Snap0[63:56] down to Snap0[7:0].
  - 9–16: Snap1[63:56] down to Snap1[7:0].
  - 17: checksum.
- **Checksum.** XOR of the 16 count bytes (Idx 1–16). The header is excluded.
- **Transfer.** A byte transfers at a posedge where Valid=1 and Ready=1.
  - Idx increments on each transfer.
  - The checksum accumulates on each transfer of Idx 1–16.
- **Frame end.** The transfer at Idx=17 returns the FSM to IDLE and sets Done for the following cycle.
- **Count changes.** Count0/Count1 changes during SEND have no effect on the frame in progress.
- **Output decode.** Busy=1 and Valid=1 exactly when in SEND. Data is a combinational function of Idx and the snapshot/checksum registers. Data=8'h00 in IDLE.

## Timing
- **Start latency.** Req sampled at edge N gives Valid=1, Data=HEADER, Busy=1 in cycle N+1.
- **Stalls.** Ready low holds Data and Idx unchanged; Valid stays high. The sink may stall any number of cycles. Valid never drops mid-frame, except on Reset.
- **Throughput.** With Ready held high the frame takes exactly 18 cycles.
  - Final transfer at edge N+18.
  - Done=1, Busy=0, Valid=0 in cycle N+19.
- **Back-to-back frames.** Req=1 during the Done cycle (IDLE) is accepted. That gives a new snapshot, and the next frame's header appears one cycle later. Done is still exactly one cycle wide.
- **Req held high.** Continuous Req produces frames back-to-back with one IDLE/Done cycle between them.
- **Reset mid-frame.** Valid, Busy and Done fall to 0 asynchronously; the partial frame is abandoned. After Reset rises, the first frame requires a fresh Req.
- **Ready in IDLE.** Ready high in IDLE is a don't-care; no transfer occurs.

## Test plan
- **Basic frame.**
  - Stimulus: Reset pulse; Count0=64'h0123456789ABCDEF, Count1=64'h3; Req one cycle; Ready=1.
  - Required: 18 bytes A5,01,23,45,67,89,AB,CD,EF,00,00,00,00,00,00,00,03,03 on consecutive cycles starting one cycle after Req. Done pulses once in the cycle after byte 17.
- **Snapshot isolation.**
  - Stimulus: same as the basic frame, but Count0 increments every cycle during the frame.
  - Required: frame bytes identical to the basic frame.
- **Backpressure.**
  - Stimulus: Ready toggles 1,0,0,1 repeating.
  - Required: no byte dropped or duplicated; Data stable while Ready=0; same 18-byte sequence; Done once.
- **Req while busy.**
  - Stimulus: Req re-asserted at Idx=5.
  - Required: ignored; exactly one frame; Busy drops after byte 17.
- **Reset mid-frame.**
  - Stimulus: Reset low asynchronously at Idx=10, then release; Req again with Count0=0, Count1=64'hFFFFFFFFFFFFFFFF.
  - Required: during reset, Valid/Busy/Data/Done = 0/0/00/0. New frame: A5, eight 00, eight FF, checksum 00.
- **Back-to-back.**
  - Stimulus: Req held high across three frames with Ready=1.
  - Required: three frames with 19-cycle period; a one-cycle Done/IDLE gap between them; each frame reflects Count values at its own accept edge.
